// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, PC step, fetch-entry layout and bubble word.
package fetch_prefetch_unit_pkg;

  localparam int ADDR_W  = 32;
  localparam int INSTR_W = 32;

  localparam logic [ADDR_W-1:0]  PC_STEP  = 32'd4;
  localparam logic [INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc_plus4;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam fetch_entry_t EMPTY_ENTRY = '{pc_plus4: 32'h0000_0000, instr: 32'h0000_0000};

  function automatic logic [ADDR_W-1:0] next_pc(input logic [ADDR_W-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit and the memory.
interface fetch_prefetch_unit_if;
  import fetch_prefetch_unit_pkg::*;

  logic                req;
  logic [ADDR_W-1:0]   addr;
  logic                ready;
  logic                rvalid;
  logic [INSTR_W-1:0]  rdata;

  modport master (output req, output addr, input ready, input rvalid, input rdata);
  modport slave  (input req, input addr, output ready, output rvalid, output rdata);

endinterface

// File: rtl/fetch_prefetch_unit_chk.sv
// Protocol checks for the fetch unit: no orphan responses, no overflow, stable pending request.
module fetch_prefetch_unit_chk
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  input logic                    req,
  input logic                    ready,
  input logic [ADDR_W-1:0]       addr,
  input logic                    rvalid,
  input logic                    branch_taken,
  input logic                    push,
  input logic [$clog2(DEPTH):0]  outstanding,
  input logic [$clog2(DEPTH):0]  count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  a_no_orphan_rvalid: assert property (@(posedge clk) disable iff (rst)
    rvalid |-> (outstanding != {CNT_W{1'b0}}));

  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    push |-> (count != CNT_W'(DEPTH)));

  // A stalled request must persist with the same address unless redirected
  a_req_held: assert property (@(posedge clk) disable iff (rst)
    (req && !ready && !branch_taken) |=> (branch_taken || (req && $stable(addr))));

endmodule

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch FIFO of fetch entries; clear wins over push/pop, head is read straight from storage.
module fetch_fifo
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    push,
  input  logic                    pop,
  input  fetch_entry_t            push_data,
  output fetch_entry_t            head,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualify push/pop against clear and emptiness
  always_comb begin
    do_push_s = push && !clear;
    do_pop_s  = pop && !clear && (count_r != {CNT_W{1'b0}});
  end

  // Storage, pointers (wrap mod DEPTH) and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= EMPTY_ENTRY;
      end
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem[wr_ptr_r] <= push_data;
        wr_ptr_r      <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Head entry and occupancy exported directly
  always_comb begin
    head  = mem[rd_ptr_r];
    count = count_r;
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch stage: owns the fetch PC, issues credit-limited in-order requests, buffers responses
// in a prefetch FIFO and discards wrong-path responses after a branch redirect.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  freeze,
  input  logic                  branch_taken,
  input  logic [ADDR_W-1:0]     branch_addr,
  fetch_prefetch_unit_if.master imem,
  output logic                  valid,
  output logic [ADDR_W-1:0]     pc_out,
  output logic [INSTR_W-1:0]    instruction
);
  localparam int               CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   CREDIT_MAX = (CNT_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [ADDR_W-1:0] fetch_pc_r, fetch_pc_nxt_s;
  logic [ADDR_W-1:0] rsp_pc_r, rsp_pc_nxt_s;
  logic [CNT_W-1:0]  outstanding_r, outstanding_nxt_s;
  logic [CNT_W-1:0]  drop_cnt_r, drop_cnt_nxt_s;
  logic [CNT_W-1:0]  count_s;
  logic [CNT_W:0]    credit_s;
  logic              req_s, accept_s, dropping_s, push_s, pop_s, valid_s;
  fetch_entry_t      head_s, push_entry_s;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (branch_taken),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_entry_s),
    .head      (head_s),
    .count     (count_s)
  );

  // Credit check uses registered state only; a same-cycle pop is not credited
  always_comb begin
    credit_s     = {1'b0, count_s} + {1'b0, outstanding_r};
    req_s        = !rst && !branch_taken && (credit_s < CREDIT_MAX);
    accept_s     = req_s && imem.ready;
    valid_s      = (count_s != CNT_ZERO);
    dropping_s   = (drop_cnt_r != CNT_ZERO);
    push_s       = imem.rvalid && !dropping_s && !branch_taken;
    pop_s        = valid_s && !freeze && !branch_taken;
    push_entry_s = '{pc_plus4: next_pc(rsp_pc_r), instr: imem.rdata};
  end

  // Next PC, response-address tracker, outstanding and drop counters
  always_comb begin
    case ({accept_s, imem.rvalid})
      2'b10:   outstanding_nxt_s = outstanding_r + CNT_ONE;
      2'b01:   outstanding_nxt_s = outstanding_r - CNT_ONE;
      default: outstanding_nxt_s = outstanding_r;
    endcase
    if (branch_taken) begin
      fetch_pc_nxt_s = branch_addr;
      rsp_pc_nxt_s   = branch_addr;
      // every request still in flight after this cycle is wrong-path
      drop_cnt_nxt_s = imem.rvalid ? (outstanding_r - CNT_ONE) : outstanding_r;
    end else begin
      fetch_pc_nxt_s = accept_s ? next_pc(fetch_pc_r) : fetch_pc_r;
      rsp_pc_nxt_s   = push_s ? next_pc(rsp_pc_r) : rsp_pc_r;
      drop_cnt_nxt_s = (imem.rvalid && dropping_s) ? (drop_cnt_r - CNT_ONE) : drop_cnt_r;
    end
  end

  // Fetch-side state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_r    <= RESET_PC;
      rsp_pc_r      <= RESET_PC;
      outstanding_r <= CNT_ZERO;
      drop_cnt_r    <= CNT_ZERO;
    end else begin
      fetch_pc_r    <= fetch_pc_nxt_s;
      rsp_pc_r      <= rsp_pc_nxt_s;
      outstanding_r <= outstanding_nxt_s;
      drop_cnt_r    <= drop_cnt_nxt_s;
    end
  end

  // Request bus and decode-facing head entry; bubble shown as zeros
  always_comb begin
    imem.req    = req_s;
    imem.addr   = fetch_pc_r;
    valid       = valid_s;
    pc_out      = valid_s ? head_s.pc_plus4 : {ADDR_W{1'b0}};
    instruction = valid_s ? head_s.instr : NOP_WORD;
  end

  fetch_prefetch_unit_chk #(.DEPTH(DEPTH)) u_chk (
    .clk          (clk),
    .rst          (rst),
    .req          (imem.req),
    .ready        (imem.ready),
    .addr         (imem.addr),
    .rvalid       (imem.rvalid),
    .branch_taken (branch_taken),
    .push         (push_s),
    .outstanding  (outstanding_r),
    .count        (count_s)
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Table-driven bench for fetch_prefetch_unit with an in-order, fixed-latency memory model.
module tb_fetch_prefetch_unit;
  import fetch_prefetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        valid;
  logic [31:0] pc_out;
  logic [31:0] instruction;

  fetch_prefetch_unit_if imem_bus();

  fetch_prefetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem         (imem_bus),
    .valid        (valid),
    .pc_out       (pc_out),
    .instruction  (instruction)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          sec;
    logic        fz;
    logic        br;
    logic [31:0] baddr;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  vec_t  tbl[$];
  pend_t pend[$];
  int    total;
  int    bad;
  int    cyc;
  int    lat;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic add(input int sec, input int fz, input int br, input logic [31:0] baddr,
                     input int rdy, input int req, input logic [31:0] addr,
                     input int vld, input logic [31:0] pc);
    vec_t v;
    v.sec = sec; v.fz = (fz != 0); v.br = (br != 0); v.baddr = baddr; v.rdy = (rdy != 0);
    v.req = (req != 0); v.addr = addr; v.vld = (vld != 0); v.pc = pc;
    tbl.push_back(v);
  endtask

  task automatic check_row(input string name, input logic req_e, input logic [31:0] addr_e,
                           input logic vld_e, input logic [31:0] pc_e);
    logic [31:0] ins_e;
    ins_e = vld_e ? word_at(pc_e - 32'd4) : 32'h0;
    total++;
    if (imem_bus.req !== req_e || imem_bus.addr !== addr_e || valid !== vld_e ||
        pc_out !== pc_e || instruction !== ins_e) begin
      bad++;
      $display("FAIL %s: got req=%b addr=%h valid=%b pc_out=%h instr=%h; expected req=%b addr=%h valid=%b pc_out=%h instr=%h",
               name, imem_bus.req, imem_bus.addr, valid, pc_out, instruction,
               req_e, addr_e, vld_e, pc_e, ins_e);
    end
  endtask

  // memory model: respond in order, lat cycles after acceptance
  task automatic drive_mem();
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata  = 32'h0;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        imem_bus.rvalid = 1'b1;
        imem_bus.rdata  = word_at(pend[0].addr);
      end
    end
  endtask

  task automatic tick();
    pend_t p;
    if (!rst) begin
      if (imem_bus.rvalid) pend.delete(0);
      if (imem_bus.req && imem_bus.ready) begin
        p.addr = imem_bus.addr;
        p.due  = cyc + lat;
        pend.push_back(p);
      end
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_bus.ready = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic run_sec(input int sec, input int l);
    lat = l;
    foreach (tbl[i]) begin
      if (tbl[i].sec == sec) begin
        freeze         = tbl[i].fz;
        branch_taken   = tbl[i].br;
        branch_addr    = tbl[i].baddr;
        imem_bus.ready = tbl[i].rdy;
        drive_mem();
        #1;
        check_row($sformatf("s%0d_c%0d", sec, cyc), tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].pc);
        tick();
      end
    end
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; lat = 1;
    rst = 1'b1;
    freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_bus.ready = 1'b1; imem_bus.rvalid = 1'b0; imem_bus.rdata = 32'h0;

    // sec 1: zero-wait stream, 6-cycle freeze, then branch+freeze with same-cycle response
    add(1, 0,0,32'h0,   1, 1,32'h0,   0,32'h0);
    add(1, 0,0,32'h0,   1, 1,32'h4,   0,32'h0);
    add(1, 1,0,32'h0,   1, 1,32'h8,   1,32'h4);
    add(1, 1,0,32'h0,   1, 1,32'hC,   1,32'h4);
    add(1, 1,0,32'h0,   1, 0,32'h10,  1,32'h4);
    add(1, 1,0,32'h0,   1, 0,32'h10,  1,32'h4);
    add(1, 1,0,32'h0,   1, 0,32'h10,  1,32'h4);
    add(1, 1,0,32'h0,   1, 0,32'h10,  1,32'h4);
    add(1, 0,0,32'h0,   1, 0,32'h10,  1,32'h4);
    add(1, 0,0,32'h0,   1, 1,32'h10,  1,32'h8);
    add(1, 0,0,32'h0,   1, 1,32'h14,  1,32'hC);
    add(1, 0,0,32'h0,   1, 1,32'h18,  1,32'h10);
    add(1, 1,1,32'h200, 1, 0,32'h1C,  1,32'h14);
    add(1, 0,0,32'h0,   1, 1,32'h200, 0,32'h0);
    add(1, 0,0,32'h0,   1, 1,32'h204, 0,32'h0);
    add(1, 0,0,32'h0,   1, 1,32'h208, 1,32'h204);
    // sec 2: latency 4, redirect with 3 outstanding, no same-cycle response
    add(2, 0,0,32'h0,   1, 1,32'h0,   0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h4,   0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h8,   0,32'h0);
    add(2, 0,1,32'h100, 1, 0,32'hC,   0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h100, 0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h104, 0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h108, 0,32'h0);
    add(2, 0,0,32'h0,   1, 1,32'h10C, 0,32'h0);
    add(2, 0,0,32'h0,   1, 0,32'h110, 0,32'h0);
    add(2, 0,0,32'h0,   1, 0,32'h110, 1,32'h104);
    add(2, 0,0,32'h0,   1, 1,32'h110, 1,32'h108);
    add(2, 0,0,32'h0,   1, 1,32'h114, 1,32'h10C);
    // sec 3: ready low for 5 cycles, FIFO drains
    add(3, 0,0,32'h0,   1, 1,32'h0,   0,32'h0);
    add(3, 0,0,32'h0,   1, 1,32'h4,   0,32'h0);
    add(3, 0,0,32'h0,   0, 1,32'h8,   1,32'h4);
    add(3, 0,0,32'h0,   0, 1,32'h8,   1,32'h8);
    add(3, 0,0,32'h0,   0, 1,32'h8,   0,32'h0);
    add(3, 0,0,32'h0,   0, 1,32'h8,   0,32'h0);
    add(3, 0,0,32'h0,   0, 1,32'h8,   0,32'h0);
    add(3, 0,0,32'h0,   1, 1,32'h8,   0,32'h0);
    add(3, 0,0,32'h0,   1, 1,32'hC,   0,32'h0);
    add(3, 0,0,32'h0,   1, 1,32'h10,  1,32'hC);
    // sec 4: latency 2 under freeze, fills FIFO before async reset
    add(4, 1,0,32'h0,   1, 1,32'h0,   0,32'h0);
    add(4, 1,0,32'h0,   1, 1,32'h4,   0,32'h0);
    add(4, 1,0,32'h0,   1, 1,32'h8,   0,32'h0);
    add(4, 1,0,32'h0,   1, 1,32'hC,   1,32'h4);
    add(4, 1,0,32'h0,   1, 0,32'h10,  1,32'h4);
    // sec 5: restart after reset, no stale words
    add(5, 0,0,32'h0,   1, 1,32'h0,   0,32'h0);
    add(5, 0,0,32'h0,   1, 1,32'h4,   0,32'h0);
    add(5, 0,0,32'h0,   1, 1,32'h8,   0,32'h0);
    add(5, 0,0,32'h0,   1, 1,32'hC,   1,32'h4);

    #1;
    check_row("reset_state", 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;

    run_sec(1, 1);
    do_reset();
    run_sec(2, 4);
    do_reset();
    run_sec(3, 1);
    do_reset();
    run_sec(4, 2);

    // mid-cycle async reset with 3 buffered entries and 1 outstanding
    rst = 1'b1;
    freeze = 1'b0;
    imem_bus.rvalid = 1'b0;
    imem_bus.rdata = 32'h0;
    #1;
    check_row("async_reset", 1'b0, 32'h0, 1'b0, 32'h0);
    pend.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    run_sec(5, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
